// File: rtl/frame_column_loader.sv
// Frame loader for one FABulous fabric column. It assembles NumRows row words
// behind a header, then writes the frame with a framed, one-hot FrameStrobe pulse.
module frame_column_loader #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 8
) (
  input  logic                                 CLK,
  input  logic                                 resetn,
  input  logic [FrameBitsPerRow-1:0]           word_i,
  input  logic                                 word_valid_i,
  output logic                                 word_ready_o,
  input  logic                                 clear_err_i,
  output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy_o,
  output logic                                 frame_done_o,
  output logic                                 err_o,
  output logic [15:0]                          frames_written_o
);

  localparam int RowW  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int IdxW  = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int DataW = FrameBitsPerRow * NumRows;
  localparam logic [7:0]      MaxIdx  = 8'(MaxFramesPerCol);
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;

  state_t                     state_q, state_d;
  logic [RowW-1:0]            row_cnt_q, row_cnt_d;
  logic [IdxW-1:0]            frame_idx_q, frame_idx_d;
  logic [DataW-1:0]           data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [15:0]                frames_written_q, frames_written_d;

  logic accept;
  logic hdr_ok;

  assign accept = word_valid_i & ready_q;
  assign hdr_ok = (word_i[31:24] == 8'hFA) && (word_i[7:0] < MaxIdx);

  always_comb begin
    state_d          = state_q;
    row_cnt_d        = row_cnt_q;
    frame_idx_d      = frame_idx_q;
    data_d           = data_q;
    strobe_d         = '0;
    done_d           = 1'b0;
    err_d            = err_q;
    frames_written_d = frames_written_q;

    if (clear_err_i) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (hdr_ok) begin
            frame_idx_d = word_i[IdxW-1:0];
            row_cnt_d   = '0;
            state_d     = LOAD;
          end else begin
            err_d = 1'b1;  // set has priority over a same-edge clear
          end
        end
      end
      LOAD: begin
        if (accept) begin
          data_d[row_cnt_q*FrameBitsPerRow +: FrameBitsPerRow] = word_i;
          if (row_cnt_q == LastRow) begin
            row_cnt_d = '0;
            state_d   = SETUP;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      SETUP: begin
        strobe_d = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << frame_idx_q;
        state_d  = STROBE;
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        done_d           = 1'b1;
        frames_written_d = frames_written_q + 16'd1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake/status flops follow the next state so outputs stay registered.
    ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      row_cnt_q        <= '0;
      frame_idx_q      <= '0;
      data_q           <= '0;
      strobe_q         <= '0;
      ready_q          <= 1'b1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      frames_written_q <= '0;
    end else begin
      state_q          <= state_d;
      row_cnt_q        <= row_cnt_d;
      frame_idx_q      <= frame_idx_d;
      data_q           <= data_d;
      strobe_q         <= strobe_d;
      ready_q          <= ready_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
      frames_written_q <= frames_written_d;
    end
  end

  assign word_ready_o     = ready_q;
  assign FrameData        = data_q;
  assign FrameStrobe      = strobe_q;
  assign busy_o           = busy_q;
  assign frame_done_o     = done_q;
  assign err_o            = err_q;
  assign frames_written_o = frames_written_q;

endmodule

// File: tb/tb_frame_column_loader.sv
// Directed bench for frame_column_loader: a per-cycle vector table plus
// hand-written sequences for gaps, back-to-back frames, reset abort and wrap.
module tb_frame_column_loader;

  logic         CLK = 1'b0;
  logic         resetn;
  logic [31:0]  word_i;
  logic         word_valid_i;
  logic         word_ready_o;
  logic         clear_err_i;
  logic [255:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         busy_o;
  logic         frame_done_o;
  logic         err_o;
  logic [15:0]  frames_written_o;

  frame_column_loader #(
    .FrameBitsPerRow(32),
    .MaxFramesPerCol(20),
    .NumRows(8)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .word_i(word_i),
    .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_o),
    .clear_err_i(clear_err_i),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy_o(busy_o),
    .frame_done_o(frame_done_o),
    .err_o(err_o),
    .frames_written_o(frames_written_o)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stb_cyc[$];
  logic [19:0] stb_val[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Log every strobe cycle seen away from the clock edge.
  always @(negedge CLK) begin
    if (FrameStrobe != 20'h0) begin
      stb_cyc.push_back(cyc);
      stb_val.push_back(FrameStrobe);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change right after a negedge; returns at the next negedge.
  task automatic step(input logic v, input logic [31:0] w, input logic clr);
    word_valid_i = v;
    word_i       = w;
    clear_err_i  = clr;
    @(negedge CLK);
  endtask

  task automatic send_frame(input logic [4:0] idx, input logic [31:0] base, input bit gaps);
    step(1'b1, {8'hFA, 16'h0, 3'b0, idx}, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (gaps) step(1'b0, 32'h0, 1'b0);
      step(1'b1, base + 32'(k), 1'b0);
    end
  endtask

  // Waits (bounded) for frame_done_o, counting samples with word_ready_o low.
  task automatic wait_done(output int low_cnt);
    bit found = 0;
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_done_o) begin
        found = 1;
        break;
      end
      if (!word_ready_o) low_cnt++;
      step(1'b0, 32'h0, 1'b0);
    end
    check("done_timeout", 64'(found), 64'd1);
  endtask

  task automatic check_rows(input string name, input logic [31:0] base);
    for (int k = 0; k < 8; k++)
      check(name, 64'(FrameData[k*32 +: 32]), 64'(base + 32'(k)));
  endtask

  typedef struct {
    logic        v;
    logic [31:0] w;
    logic        clr;
    logic        rdy;
    logic        busy;
    logic [19:0] stb;
    logic        done;
    logic        err;
    logic [15:0] frames;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int lc;
    int n0;

    // header idx 3, rows, strobe/hold/done, then bad headers and err clearing
    vecs[0] = '{1'b1, 32'hFA000003, 1'b0, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0, 16'd0};
    for (int k = 0; k < 8; k++)
      vecs[1+k] = '{1'b1, 32'h1000_0000 + 32'(k), 1'b0, (k != 7), 1'b1, 20'h0, 1'b0, 1'b0, 16'd0};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 20'h00008, 1'b0, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 20'h0,     1'b0, 1'b0, 16'd0};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 20'h0,     1'b1, 1'b0, 16'd1};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 16'd1};
    vecs[13] = '{1'b1, 32'hFA000014, 1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 1'b1, 16'd1};
    vecs[14] = '{1'b1, 32'h12000001, 1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 1'b1, 16'd1};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 16'd1};
    vecs[16] = '{1'b1, 32'hFB000002, 1'b1, 1'b1, 1'b0, 20'h0,     1'b0, 1'b1, 16'd1};
    vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 16'd1};

    resetn = 1'b0;
    word_i = '0;
    word_valid_i = 1'b0;
    clear_err_i = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_ready",  64'(word_ready_o), 64'd1);
    check("rst_busy",   64'(busy_o), 64'd0);
    check("rst_strobe", 64'(FrameStrobe), 64'd0);
    check("rst_data",   64'(FrameData != '0), 64'd0);
    check("rst_frames", 64'(frames_written_o), 64'd0);
    resetn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].v, vecs[i].w, vecs[i].clr);
      check($sformatf("vec%0d_ready", i),  64'(word_ready_o), 64'(vecs[i].rdy));
      check($sformatf("vec%0d_busy", i),   64'(busy_o), 64'(vecs[i].busy));
      check($sformatf("vec%0d_strobe", i), 64'(FrameStrobe), 64'(vecs[i].stb));
      check($sformatf("vec%0d_done", i),   64'(frame_done_o), 64'(vecs[i].done));
      check($sformatf("vec%0d_err", i),    64'(err_o), 64'(vecs[i].err));
      check($sformatf("vec%0d_frames", i), 64'(frames_written_o), 64'(vecs[i].frames));
    end
    check_rows("frame3_rows", 32'h1000_0000);
    check("frame3_strobe_count", 64'(stb_val.size()), 64'd1);

    // index 19 with valid toggling every other cycle
    n0 = stb_val.size();
    send_frame(5'd19, 32'h2000_0000, 1'b1);
    wait_done(lc);
    check("gap_ready_low_cycles", 64'(lc), 64'd3);
    check_rows("gap_rows", 32'h2000_0000);
    check("gap_strobe_count", 64'(stb_val.size() - n0), 64'd1);
    if (stb_val.size() > n0) check("gap_strobe_val", 64'(stb_val[n0]), 64'h80000);
    check("gap_frames", 64'(frames_written_o), 64'd2);

    // back-to-back: second header presented in the frame_done_o cycle
    n0 = stb_val.size();
    send_frame(5'd0, 32'h3000_0000, 1'b0);
    wait_done(lc);
    check("b2b_ready_in_done", 64'(word_ready_o), 64'd1);
    send_frame(5'd1, 32'h4000_0000, 1'b0);
    wait_done(lc);
    check_rows("b2b_rows", 32'h4000_0000);
    check("b2b_strobe_count", 64'(stb_val.size() - n0), 64'd2);
    if (stb_val.size() >= n0 + 2) begin
      check("b2b_strobe0", 64'(stb_val[n0]), 64'h1);
      check("b2b_strobe1", 64'(stb_val[n0+1]), 64'h2);
      check("b2b_period", 64'(stb_cyc[n0+1] - stb_cyc[n0]), 64'd12);
    end
    check("b2b_frames", 64'(frames_written_o), 64'd4);

    // reset asserted after row 4 aborts the frame
    n0 = stb_val.size();
    step(1'b1, 32'hFA000007, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 32'h5000_0000 + 32'(k), 1'b0);
    word_valid_i = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("abort_data",   64'(FrameData != '0), 64'd0);
    check("abort_strobe", 64'(FrameStrobe), 64'd0);
    check("abort_ready",  64'(word_ready_o), 64'd1);
    check("abort_busy",   64'(busy_o), 64'd0);
    check("abort_done",   64'(frame_done_o), 64'd0);
    check("abort_err",    64'(err_o), 64'd0);
    check("abort_frames", 64'(frames_written_o), 64'd0);
    repeat (4) @(negedge CLK);
    check("abort_no_strobe", 64'(stb_val.size() - n0), 64'd0);
    resetn = 1'b1;
    @(negedge CLK);
    send_frame(5'd5, 32'h6000_0000, 1'b0);
    wait_done(lc);
    check_rows("post_abort_rows", 32'h6000_0000);
    check("post_abort_strobe_count", 64'(stb_val.size() - n0), 64'd1);
    if (stb_val.size() > n0) check("post_abort_strobe", 64'(stb_val[n0]), 64'h20);
    check("post_abort_frames", 64'(frames_written_o), 64'd1);

    // counter wrap, preloaded to 16'hFFFF across one edge
    step(1'b0, 32'h0, 1'b0);
    force dut.frames_written_q = 16'hFFFF;
    @(negedge CLK);
    release dut.frames_written_q;
    @(negedge CLK);
    check("wrap_preload", 64'(frames_written_o), 64'hFFFF);
    send_frame(5'd2, 32'h7000_0000, 1'b0);
    wait_done(lc);
    check("wrap_frames", 64'(frames_written_o), 64'd0);
    check("wrap_done", 64'(frame_done_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/frame_column_loader.md
# frame_column_loader

Sequencer that writes configuration frames into one fabric column of FABulous tiles, such as the W_IO edge tile, through their FrameData/FrameStrobe config ports. It accepts a word stream from the bitstream source with a valid/ready handshake and assembles one frame of NumRows row-words. It then drives the column-wide FrameData bus and pulses exactly one FrameStrobe bit with a setup and hold margin. The block sits between the global config port and the top of a column's FrameData/FrameStrobe daisy chain.

## Interface
- FrameBitsPerRow, 32, width of one row word and of each tile's FrameData slice
- MaxFramesPerCol, 20, number of FrameStrobe lines per column
- NumRows, 8, tiles in the column; one row word per tile per frame
- CLK  in  1  config clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- word_i  in  FrameBitsPerRow  stream word (header or row data)
- word_valid_i  in  1  word_i valid
- word_ready_o  out  1  block accepts word_i this cycle
- clear_err_i  in  1  synchronous clear of err_o
- FrameData  out  FrameBitsPerRow*NumRows  column frame data; row k at [k*FrameBitsPerRow +: FrameBitsPerRow]
- FrameStrobe  out  MaxFramesPerCol  one-hot frame write strobe
- busy_o  out  1  high in any state other than IDLE
- frame_done_o  out  1  one-cycle pulse per completed frame write
- err_o  out  1  sticky bad-header flag
- frames_written_o  out  16  count of completed frames, wraps at 65535 -> 0

## Operation
- A word is accepted on a rising edge when word_valid_i and word_ready_o are both high. word_ready_o is high only in IDLE and LOAD.
- The FSM has five states: IDLE, LOAD, SETUP, STROBE, HOLD.
- IDLE: the accepted word is a header. The header is valid when word_i[31:24]==8'hFA and word_i[7:0] < MaxFramesPerCol.
  - Valid header: latch the index into frame_idx, clear row_cnt, go to LOAD.
  - Invalid header: set err_o, discard the word, stay in IDLE.
- LOAD: each accepted word is written to FrameData row row_cnt, and row_cnt increments.
  - When the word for row NumRows-1 is accepted, go to SETUP.
  - A gap in word_valid_i simply stalls; there is no timeout.
- SETUP: one cycle; FrameData is stable and FrameStrobe is all zero. Go to STROBE.
- STROBE: one cycle with FrameStrobe = 1<<frame_idx. Go to HOLD.
- HOLD: one cycle with FrameStrobe zero and FrameData unchanged.
  - Go to IDLE, assert frame_done_o for the next cycle (the first IDLE cycle), and increment frames_written_o.
- FrameData is registered. It changes only on an accepted LOAD word and is not cleared between frames, so unwritten rows keep their previous value.
- err_o is set by an invalid header and cleared by clear_err_i. If both happen on the same edge, set wins.
- row_cnt is $clog2(NumRows) bits wide, min 1. frame_idx is $clog2(MaxFramesPerCol) bits wide.
- Header bits [23:8] are ignored.

## Timing
- Reset values while resetn is low, applied asynchronously: state IDLE, FrameData 0, FrameStrobe 0, word_ready_o 1, busy_o 0, frame_done_o 0, err_o 0, frames_written_o 0, row_cnt 0.
- Reset asserted mid-frame aborts the frame. No strobe occurs, and partial FrameData is zeroed.
- Frame timing, with the header accepted on edge h and back-to-back valid data:
  - Row k is written on edge h+1+k.
  - The last row is on edge h+NumRows.
  - SETUP spans the cycle after edge h+NumRows. STROBE spans the next cycle, and HOLD the one after.
  - frame_done_o is high, and word_ready_o high again, in the cycle starting at edge h+NumRows+3.
- The minimum frame period is NumRows+4 cycles.
- FrameStrobe is high for exactly one cycle per frame. It never changes in the same cycle as FrameData: at least one quiet cycle before and after.
- A header can be accepted in the same cycle frame_done_o is high.
- All outputs are driven from registers; there are no combinational paths from word_i to outputs.

## Test plan
- Reset, then header 32'hFA000003 and rows 0..7 = 32'h1000_0000+k, valid held high:
  - FrameData rows hold 32'h1000_0000..32'h1000_0007.
  - FrameStrobe==20'h00008 for exactly one cycle, 2 cycles after the last row is accepted.
  - frame_done_o pulses once; frames_written_o==1.
- Header 32'hFA000014 (index 20), then header 32'h12000001:
  - err_o rises after the first word; both words are discarded and FrameStrobe stays 0.
  - clear_err_i for 1 cycle -> err_o==0.
- Valid header index 19, then 8 rows with word_valid_i toggling every other cycle:
  - Rows land correctly; the strobe is 20'h80000 once; word_ready_o is low only during SETUP/STROBE/HOLD.
- Two back-to-back frames (index 0, then index 1), with the second header presented during the frame_done_o cycle:
  - The header is accepted that cycle; the strobes 20'h00001 and 20'h00002 are NumRows+4 cycles apart.
- Assert resetn low after row 4 of a frame:
  - All outputs go to their reset values immediately; no strobe; after release, a full frame completes normally.
- Run 65536 frames (shortened via forced counter preload to 16'hFFFF): the next completed frame -> frames_written_o==0.
